// File: rtl/ucore_pkg.sv
// Shared types and constants for the ucore firing controller.
package ucore_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        OUT  = 2'd2
    } ucore_fire_state_e;

    localparam int UCORE_PERF_W = 32;

endpackage

// File: rtl/ucore_perf_cnt.sv
// Event counter for the firing controller; wraps by default, optionally saturates.
module ucore_perf_cnt
    import ucore_pkg::*;
#(
    parameter int W        = UCORE_PERF_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            if (SATURATE && (&cnt)) begin
                cnt <= cnt;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/ucore_fire_ctrl.sv
// Operand-gathering firing controller between input FIFOs, the FU and the NoC.
// Optional performance counters are built when UCORE_FIRE_PERF_EN is defined.
module ucore_fire_ctrl
    import ucore_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [N-1:0]            cfg_use_mask,
    input  logic [N-1:0]            cfg_const_mask,
    input  logic [N-1:0]            in_valid,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic [N-1:0]            in_yumi,
    output logic                    fu_start,
    output logic [N*DATA_WIDTH-1:0] fu_opnd,
    input  logic                    fu_done,
    input  logic [DATA_WIDTH-1:0]   fu_result,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output ucore_fire_state_e       dbg_state
`ifdef UCORE_FIRE_PERF_EN
    ,
    output logic [UCORE_PERF_W-1:0] perf_fire_cnt,
    output logic [UCORE_PERF_W-1:0] perf_stall_cnt
`endif
);

    // Handshakes: inputs are valid-then-yumi (yumi only on a lane already
    // valid, same cycle); the output is valid/ready, transfer when both are 1,
    // and out_valid/out_data hold until that transfer.

    ucore_fire_state_e       state_q;
    logic [N-1:0]            use_mask;
    logic [N-1:0]            const_mask;
    logic [DATA_WIDTH-1:0]   res_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    fire_ok;
    logic                    fire;

    assign fire_ok = (use_mask != '0) && ((in_valid & use_mask) == use_mask);

    always_comb begin
        fire = 1'b0;
        case (state_q)
            IDLE:    fire = !cfg_we && fire_ok;
            OUT:     fire = out_ready && fire_ok;
            default: fire = 1'b0;
        endcase
    end

    always_comb begin
        fu_opnd = '0;
        for (int i = 0; i < N; i++) begin
            if (fire && use_mask[i]) begin
                fu_opnd[i*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fu_start  = fire;
    assign in_yumi   = fire ? (use_mask & ~const_mask) : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? res_q : '0;
    assign busy      = busy_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            use_mask    <= '0;
            const_mask  <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A config write wins over a fire in the same cycle.
                    if (cfg_we) begin
                        use_mask   <= cfg_use_mask;
                        const_mask <= cfg_const_mask;
                    end else if (fire_ok) begin
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (fu_done) begin
                        res_q       <= fu_result;
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (fire_ok) begin
                            state_q <= EXEC;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef UCORE_FIRE_PERF_EN
    ucore_perf_cnt #(.W(UCORE_PERF_W), .SATURATE(1'b0)) u_fire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fire),
        .cnt   (perf_fire_cnt)
    );

    ucore_perf_cnt #(.W(UCORE_PERF_W), .SATURATE(1'b0)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_q == OUT) && out_valid_q && !out_ready),
        .cnt   (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ucore_fire_ctrl.sv
// Directed, table-driven bench for ucore_fire_ctrl (N=2, DATA_WIDTH=32).
module tb_ucore_fire_ctrl;

    localparam int W = 32;
    localparam int N = 2;

    logic            clk;
    logic            rst_n;
    logic            cfg_we;
    logic [N-1:0]    cfg_use_mask;
    logic [N-1:0]    cfg_const_mask;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_yumi;
    logic            fu_start;
    logic [N*W-1:0]  fu_opnd;
    logic            fu_done;
    logic [W-1:0]    fu_result;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready;
    logic            busy;
    ucore_pkg::ucore_fire_state_e dbg_state;
`ifdef UCORE_FIRE_PERF_EN
    logic [31:0]     perf_fire_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    ucore_fire_ctrl #(.DATA_WIDTH(W), .N(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we),
        .cfg_use_mask   (cfg_use_mask),
        .cfg_const_mask (cfg_const_mask),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_yumi        (in_yumi),
        .fu_start       (fu_start),
        .fu_opnd        (fu_opnd),
        .fu_done        (fu_done),
        .fu_result      (fu_result),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .busy           (busy),
        .dbg_state      (dbg_state)
`ifdef UCORE_FIRE_PERF_EN
        ,
        .perf_fire_cnt  (perf_fire_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        cfg_we;
        logic [1:0]  use_m;
        logic [1:0]  const_m;
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        done;
        logic [31:0] res;
        logic        ready;
        logic        e_start;
        logic [1:0]  e_yumi;
        logic [63:0] e_opnd;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t        vecs[$];
    logic [W-1:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic cw, input logic [1:0] um, input logic [1:0] cm,
                       input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic dn, input logic [31:0] rs, input logic rd,
                       input logic es, input logic [1:0] ey, input logic [31:0] eo1,
                       input logic [31:0] eo0, input logic ev, input logic [31:0] ed,
                       input logic eb);
        vec_t v_r;
        v_r.cfg_we = cw; v_r.use_m = um; v_r.const_m = cm; v_r.valid = v;
        v_r.d0 = d0; v_r.d1 = d1; v_r.done = dn; v_r.res = rs; v_r.ready = rd;
        v_r.e_start = es; v_r.e_yumi = ey; v_r.e_opnd = {eo1, eo0};
        v_r.e_valid = ev; v_r.e_data = ed; v_r.e_busy = eb;
        vecs.push_back(v_r);
    endtask

    // driver: inputs change after the falling edge, outputs sampled 2ns later
    task automatic apply(input vec_t v, input int idx);
        logic [W-1:0] exp_res;
        @(negedge clk);
        cfg_we         = v.cfg_we;
        cfg_use_mask   = v.use_m;
        cfg_const_mask = v.const_m;
        in_valid       = v.valid;
        in_data        = {v.d1, v.d0};
        fu_done        = v.done;
        fu_result      = v.res;
        out_ready      = v.ready;
        #2;
        check($sformatf("r%0d fu_start", idx), 64'(fu_start), 64'(v.e_start));
        check($sformatf("r%0d in_yumi", idx), 64'(in_yumi), 64'(v.e_yumi));
        check($sformatf("r%0d fu_opnd", idx), fu_opnd, v.e_opnd);
        check($sformatf("r%0d out_valid", idx), 64'(out_valid), 64'(v.e_valid));
        check($sformatf("r%0d out_data", idx), 64'(out_data), 64'(v.e_data));
        check($sformatf("r%0d busy", idx), 64'(busy), 64'(v.e_busy));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check($sformatf("r%0d unexpected result", idx), 64'(out_data), 64'hDEAD);
            end else begin
                exp_res = exp_q.pop_front();
                check($sformatf("r%0d scoreboard", idx), 64'(out_data), 64'(exp_res));
            end
        end
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_use_mask = 0; cfg_const_mask = 0; in_valid = 0;
        in_data = '0; fu_done = 0; fu_result = '0; out_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // cw um cm  v  d0 d1 dn res rd | st yumi op1 op0 ov odata busy
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);        // reset state
        add(1, 3, 0, 3, 5, 7, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);        // config, no fire
        add(0, 0, 0, 3, 5, 7, 0, 0, 0,   1, 3, 7, 5, 0, 0, 0);        // fire {7,5}
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);        // EXEC wait
        add(0, 0, 0, 0, 0, 0, 1, 12, 0,  0, 0, 0, 0, 0, 0, 1);        // fu_done 12
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 12, 1);       // OUT accept
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);      // ch1 empty
        add(0, 0, 0, 3, 3, 4, 0, 0, 1,   1, 3, 4, 3, 0, 0, 0);        // ch1 arrives
        add(0, 0, 0, 0, 0, 0, 1, 99, 0,  0, 0, 0, 0, 0, 0, 1);        // done at t+1
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 99, 1);     // stall
        add(0, 0, 0, 3, 8, 9, 0, 0, 1,   1, 3, 9, 8, 1, 99, 1);       // accept + re-fire
        add(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);        // cfg in EXEC ignored
        add(0, 0, 0, 0, 0, 0, 1, 17, 0,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 17, 1);       // masks still 11
        add(1, 3, 2, 3, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);        // cfg beats fire_ok
        add(0, 0, 0, 3, 10, 20, 0, 0, 0, 1, 1, 20, 10, 0, 0, 0);      // const ch1
        add(0, 0, 0, 0, 0, 0, 1, 30, 0,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 3, 11, 20, 0, 0, 1, 1, 1, 20, 11, 1, 30, 1);
        add(0, 0, 0, 0, 0, 0, 1, 31, 0,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 3, 12, 20, 0, 0, 1, 1, 1, 20, 12, 1, 31, 1);
        add(0, 0, 0, 0, 0, 0, 1, 32, 0,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 32, 1);
        add(1, 1, 2, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);        // const bit w/o use
        add(0, 0, 0, 1, 6, 55, 0, 0, 0,  1, 1, 0, 6, 0, 0, 0);        // lane 1 zeroed
        add(0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 7, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);

        exp_q.push_back(32'd12); exp_q.push_back(32'd99); exp_q.push_back(32'd17);
        exp_q.push_back(32'd30); exp_q.push_back(32'd31); exp_q.push_back(32'd32);
        exp_q.push_back(32'd7);

`ifdef UCORE_FIRE_PERF_EN
        #1;
        check("perf_fire reset", 64'(perf_fire_cnt), 64'd0);
        check("perf_stall reset", 64'(perf_stall_cnt), 64'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

`ifdef UCORE_FIRE_PERF_EN
        check("perf_fire_cnt", 64'(perf_fire_cnt), 64'd7);
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'd4);
`endif

        // reset during EXEC
        @(negedge clk);
        idle_inputs();
        cfg_we = 1; cfg_use_mask = 2'b11;
        @(negedge clk);
        cfg_we = 0; in_valid = 2'b11; in_data = {32'd2, 32'd40};
        #2;
        check("rst seq fire", 64'(fu_start), 64'd1);
        @(negedge clk);
        in_valid = 0;
        #2;
        check("rst seq busy before", 64'(busy), 64'd1);
        check("rst seq state EXEC", 64'(dbg_state), 64'd1);
        #1;
        rst_n = 1'b0;
        in_valid = 2'b11;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst state", 64'(dbg_state), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", 64'(out_data), 64'd0);
        check("rst fu_start", 64'(fu_start), 64'd0);
        check("rst in_yumi", 64'(in_yumi), 64'd0);
        check("rst fu_opnd", fu_opnd, 64'd0);
`ifdef UCORE_FIRE_PERF_EN
        check("rst perf_fire", 64'(perf_fire_cnt), 64'd0);
        check("rst perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        fu_done = 1; fu_result = 32'd77; out_ready = 1;
        @(negedge clk);
        fu_done = 0;
        // masks were cleared, so valid operands must not fire either
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("post-rst out_valid c%0d", i), 64'(out_valid), 64'd0);
            check($sformatf("post-rst busy c%0d", i), 64'(busy), 64'd0);
            check($sformatf("post-rst fu_start c%0d", i), 64'(fu_start), 64'd0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
